// File: rtl/ama_riscv_fetch.sv
// Instruction fetch initiator: PC generation, imem request/response pairing and instruction FIFO.
// Optional perf counters are built when AMA_RISCV_FETCH_PERF_EN is defined.
module ama_riscv_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_data,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [31:0] rsp_data,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_drop_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [29:0]   pcq_mem [FIFO_DEPTH];
    logic [PW-1:0] pcq_wr_q, pcq_wr_d;
    logic [PW-1:0] pcq_rd_q, pcq_rd_d;

    logic [31:0]   fifo_data_mem [FIFO_DEPTH];
    logic [31:0]   fifo_pc_mem   [FIFO_DEPTH];
    logic [PW-1:0] fifo_wr_q, fifo_wr_d;
    logic [PW-1:0] fifo_rd_q, fifo_rd_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic [CW:0] credit_used;
    logic        credit_ok;
    logic        issue_ok;
    logic        req_fire;
    logic        rsp_fire;
    logic        discard;
    logic        inst_push;
    logic        inst_pop;

    // Credit counts in-flight plus buffered fetches so every response always finds FIFO space.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
    assign credit_ok   = credit_used < DEPTH_W;
    assign issue_ok    = credit_ok && !flush;

    assign req_valid  = rst && issue_ok;
    assign req_data   = {2'b00, pc_q[31:2]};
    assign rsp_ready  = 1'b1;
    assign inst_valid = rst && (fifo_cnt_q != '0);
    assign inst_data  = fifo_data_mem[fifo_rd_q];
    assign inst_pc    = fifo_pc_mem[fifo_rd_q];

    assign req_fire  = req_valid && req_ready;
    assign rsp_fire  = rst && rsp_valid && (outstanding_q != '0);
    assign discard   = rsp_fire && (drop_cnt_q != '0);
    assign inst_push = rsp_fire && !discard && !flush;
    assign inst_pop  = inst_valid && inst_ready && !flush;

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        pcq_wr_d      = pcq_wr_q;
        pcq_rd_d      = pcq_rd_q;

        if (flush) begin
            pc_d = flush_pc & 32'hFFFF_FFFC;
        end else if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end

        case ({req_fire, rsp_fire})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        // A redirect re-arms the drop count with everything still in flight after this cycle.
        if (flush) begin
            drop_cnt_d = outstanding_q - CW'(rsp_fire);
        end else if (discard) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end

        if (req_fire) begin
            pcq_wr_d = pcq_wr_q + PW'(1);
        end
        if (rsp_fire) begin
            pcq_rd_d = pcq_rd_q + PW'(1);
        end
    end

    always_comb begin
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q;

        if (flush) begin
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            fifo_cnt_d = '0;
        end else begin
            if (inst_push) begin
                fifo_wr_d = fifo_wr_q + PW'(1);
            end
            if (inst_pop) begin
                fifo_rd_d = fifo_rd_q + PW'(1);
            end
            case ({inst_push, inst_pop})
                2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
                2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= RESET_PC & 32'hFFFF_FFFC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            pcq_wr_q      <= '0;
            pcq_rd_q      <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            pcq_wr_q      <= pcq_wr_d;
            pcq_rd_q      <= pcq_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // Storage arrays carry no reset; pointers and counts define which entries are live.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_mem[pcq_wr_q] <= pc_q[31:2];
        end
        if (inst_push) begin
            fifo_data_mem[fifo_wr_q] <= rsp_data;
            fifo_pc_mem[fifo_wr_q]   <= {pcq_mem[pcq_rd_q], 2'b00};
        end
    end

`ifdef AMA_RISCV_FETCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] drop_evt_q, drop_evt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        drop_evt_d  = drop_evt_q;
        if (rst && !flush && !credit_ok && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (discard && (drop_evt_q != 32'hFFFF_FFFF)) begin
            drop_evt_d = drop_evt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            drop_evt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            drop_evt_q  <= drop_evt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_drop_cnt  = drop_evt_q;
`else
    assign perf_stall_cnt = 32'h0;
    assign perf_drop_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Directed bench for ama_riscv_fetch with a busy-gated imem model of configurable latency.
// Perf-counter expectations follow AMA_RISCV_FETCH_PERF_EN.
module tb_ama_riscv_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b1;
    logic [31:0] req_data;
    logic        rsp_valid = 1'b0;
    logic        rsp_ready;
    logic [31:0] rsp_data = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_drop_cnt;

    int total = 0;
    int bad = 0;
    int lat = 1;
    int busy = 0;
    logic [31:0] held = 32'h0;
    int cycleNo = 0;
    int lastFire = -1;
    bit checkSpacing = 1'b0;
    int reqFires = 0;

    typedef struct {
        logic        ready;
        logic        fl;
        logic [31:0] fpc;
        logic        exp_rv;
        logic [31:0] exp_rd;
        logic        exp_iv;
        logic [31:0] exp_ipc;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    ama_riscv_fetch #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .perf_stall_cnt(perf_stall_cnt),
        .perf_drop_cnt (perf_drop_cnt)
    );

    function automatic logic [31:0] instWord(input logic [31:0] w);
        return w ^ 32'h5A00_0013;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rdy, input logic fl, input logic [31:0] fpc);
        rst        = r;
        inst_ready = rdy;
        flush      = fl;
        flush_pc   = fpc;
        #1;
    endtask

    // One clock: sample the request handshake, clock, then present the imem outputs for the next cycle.
    task automatic advance();
        logic        fire;
        logic [31:0] word;
        #1;
        fire = req_valid && req_ready;
        word = req_data;
        if (fire) begin
            reqFires++;
            if (checkSpacing && lastFire >= 0)
                checkOutput("req_spacing", 32'(cycleNo - lastFire), 32'(lat));
            lastFire = cycleNo;
        end
        @(posedge clk);
        if (!rst) begin
            busy = 0;
        end else if (fire) begin
            busy = lat;
            held = word;
        end else if (busy > 0) begin
            busy--;
        end
        @(negedge clk);
        rsp_valid = (busy == 1);
        rsp_data  = instWord(held);
        req_ready = (busy <= 1);
        cycleNo++;
    endtask

    task automatic doReset(input int latency);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rst_req_valid", 32'(req_valid), 32'h0);
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'h0);
        lat = latency;
        repeat (3) advance();
        checkOutput("rst_perf_stall", perf_stall_cnt, 32'h0);
        checkOutput("rst_perf_drop", perf_drop_cnt, 32'h0);
        lastFire = -1;
        checkSpacing = 1'b0;
        reqFires = 0;
        cycleNo = 0;
    endtask

    task automatic expectInst(input logic [31:0] pc, input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            inst_ready = 1'b1;
            #1;
            if (inst_valid) begin
                checkOutput({tag, "_pc"}, inst_pc, pc);
                checkOutput({tag, "_data"}, inst_data, instWord({2'b00, pc[31:2]}));
                seen = 1'b1;
            end
            advance();
        end
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout: no inst_valid within %0d cycles, want pc 0x%08h", tag, budget, pc);
        end
    endtask

    initial begin
        // D=1 stream from reset, then a redirect to 0x43 (low bits ignored) at cycle 6.
        vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,  1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h1,  1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h2,  1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h3,  1'b1, 32'h4};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h4,  1'b1, 32'h8};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h5,  1'b1, 32'hC};
        vecs[6]  = '{1'b1, 1'b1, 32'h43,  1'b0, 32'h0,  1'b1, 32'h10};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h11, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h12, 1'b1, 32'h40};
        vecs[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h13, 1'b1, 32'h44};

        $display("[TB] table: D=1 stream and redirect");
        doReset(1);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, vecs[i].ready, vecs[i].fl, vecs[i].fpc);
            checkOutput($sformatf("t1_c%0d_req_valid", i), 32'(req_valid), 32'(vecs[i].exp_rv));
            if (vecs[i].exp_rv)
                checkOutput($sformatf("t1_c%0d_req_data", i), req_data, vecs[i].exp_rd);
            checkOutput($sformatf("t1_c%0d_inst_valid", i), 32'(inst_valid), 32'(vecs[i].exp_iv));
            if (vecs[i].exp_iv) begin
                checkOutput($sformatf("t1_c%0d_inst_pc", i), inst_pc, vecs[i].exp_ipc);
                checkOutput($sformatf("t1_c%0d_inst_data", i), inst_data,
                            instWord({2'b00, vecs[i].exp_ipc[31:2]}));
            end
            advance();
        end

        $display("[TB] D=3 stream of 20 instructions");
        doReset(3);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkSpacing = 1'b1;
        for (int i = 0; i < 20; i++)
            expectInst(32'(i * 4), 10, $sformatf("t2_i%0d", i));
        checkSpacing = 1'b0;

        $display("[TB] decode stalled, credit limit");
        doReset(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (12) advance();
        checkOutput("t3_req_count", 32'(reqFires), 32'd4);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t3_c12_req_valid", 32'(req_valid), 32'h0);
        checkOutput("t3_c12_inst_valid", 32'(inst_valid), 32'h1);
        checkOutput("t3_c12_inst_pc", inst_pc, 32'h0);
`ifdef AMA_RISCV_FETCH_PERF_EN
        checkOutput("t3_perf_stall", perf_stall_cnt, 32'd8);
`else
        checkOutput("t3_perf_stall", perf_stall_cnt, 32'd0);
`endif
        advance();
        checkOutput("t3_c13_req_valid", 32'(req_valid), 32'h1);
        checkOutput("t3_c13_req_data", req_data, 32'h4);
        checkOutput("t3_c13_inst_pc", inst_pc, 32'h4);
        advance();
        expectInst(32'h8, 5, "t3_next");

        $display("[TB] D=3 redirect with one request in flight");
        doReset(3);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        advance();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h103);
        checkOutput("t4_flush_req_valid", 32'(req_valid), 32'h0);
        advance();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        expectInst(32'h100, 20, "t4a");
        expectInst(32'h104, 10, "t4b");
`ifdef AMA_RISCV_FETCH_PERF_EN
        checkOutput("t4_perf_drop", perf_drop_cnt, 32'd1);
`else
        checkOutput("t4_perf_drop", perf_drop_cnt, 32'd0);
`endif

        $display("[TB] redirect in the same cycle as a response");
        doReset(3);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (3) advance();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
        checkOutput("t5_flush_req_valid", 32'(req_valid), 32'h0);
        advance();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t5_post_inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("t5_post_req_valid", 32'(req_valid), 32'h1);
        checkOutput("t5_post_req_data", req_data, 32'h80);
        advance();
        expectInst(32'h200, 20, "t5");

        $display("[TB] reset mid-stream with a full-ish FIFO");
        doReset(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (4) advance();
        checkOutput("t6_pre_inst_valid", 32'(inst_valid), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t6_rst_req_valid", 32'(req_valid), 32'h0);
        checkOutput("t6_rst_inst_valid", 32'(inst_valid), 32'h0);
        advance();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t6_rel_inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("t6_rel_req_valid", 32'(req_valid), 32'h1);
        checkOutput("t6_rel_req_data", req_data, 32'h0);
        advance();
        expectInst(32'h0, 5, "t6a");
        expectInst(32'h4, 5, "t6b");

        $display("[TB] back-to-back redirects and PC wrap");
        doReset(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (4) advance();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h300);
        advance();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        advance();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t7_c6_req_valid", 32'(req_valid), 32'h1);
        checkOutput("t7_c6_req_data", req_data, 32'h3FFF_FFFF);
        checkOutput("t7_c6_inst_valid", 32'(inst_valid), 32'h0);
        advance();
        checkOutput("t7_c7_req_data", req_data, 32'h0);
        advance();
        expectInst(32'hFFFF_FFFC, 5, "t7a");
        expectInst(32'h0, 5, "t7b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
